// File: rtl/adc_fifo_pkg.sv
// Constants shared by the ADC sample FIFO and the FIR input stage.
package adc_fifo_pkg;

    localparam int ADC_DATA_W      = 12;
    localparam int FIFO_DEPTH_LOG2 = 4;

endpackage

// File: rtl/adc_sample_fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered read that holds
// its last value when no read is requested.
module fifo_mem
    import adc_fifo_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W,
    parameter int ADDR_W = FIFO_DEPTH_LOG2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    // Storage is left unreset so it maps onto LUT RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_sample_fifo.sv
// ADC sample FIFO: buffers XADC samples for the FIR, with occupancy
// tracking and a sticky overflow flag for dropped samples.
module adc_sample_fifo
    import adc_fifo_pkg::*;
#(
    parameter int DATA_W     = ADC_DATA_W,
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
    input  logic                  clk_78MHz_i,
    input  logic                  reset_i,
    input  logic [DATA_W-1:0]     sample_i,
    input  logic                  sample_valid_i,
    input  logic                  rd_en_i,
    output logic [DATA_W-1:0]     data_o,
    output logic                  valid_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overflow_o,
    input  logic                  clear_ovf_i
);

    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  wr_acc, rd_acc, drop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    always_comb begin
        rd_acc   = rd_en_i && !empty_o;
        wr_acc   = sample_valid_i && (!full_o || rd_acc);
        drop     = sample_valid_i && full_o && !rd_acc;
        wr_ptr_d = wr_acc ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
        valid_d  = rd_acc;
        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d    = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_78MHz_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clk_i   (clk_78MHz_i),
        .rst_i   (reset_i),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (sample_i),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (data_o)
    );

    assign valid_o    = valid_q;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: doc/adc_sample_fifo.md
# adc_sample_fifo

Synchronous sample FIFO that sits directly downstream of the XADC wrapper and upstream of the FIR filter. It captures each 12-bit converted sample on the wrapper's one-cycle ready pulse, buffers up to DEPTH samples, and hands them to the FIR on request with a registered read port. It also tracks occupancy and flags dropped samples with a sticky overflow flag.

## Interface

- DATA_W, 12: sample width; matches the ADC output.
- DEPTH_LOG2, 4: log2 of the number of entries (default 16).
- clk_78MHz_i  in  1: system clock, shared with the ADC wrapper and the FIR.
- reset_i  in  1: synchronous, active-high reset.
- sample_i  in  DATA_W: ADC sample, qualified by sample_valid_i.
- sample_valid_i  in  1: one-cycle write strobe, driven by the ADC ready pulse.
- rd_en_i  in  1: read request from the FIR.
- data_o  out  DATA_W: registered read data.
- valid_o  out  1: one-cycle pulse; data_o holds a new sample.
- empty_o  out  1: count == 0.
- full_o  out  1: count == DEPTH.
- count_o  out  DEPTH_LOG2+1: current occupancy, 0..DEPTH.
- overflow_o  out  1: sticky flag; at least one sample was dropped.
- clear_ovf_i  in  1: clears overflow_o.

## Operation

- Storage: DEPTH x DATA_W memory with write pointer wr_ptr and read pointer rd_ptr, each DEPTH_LOG2 bits wide. Both pointers wrap modulo DEPTH by natural overflow. Occupancy is held in a separate count register.
- Write accept (wr_acc): sample_valid_i && (!full_o || rd_acc). The sample is stored at wr_ptr and wr_ptr increments.
- Read accept (rd_acc): rd_en_i && !empty_o. The entry at rd_ptr is registered into data_o, valid_o is asserted on the next cycle, and rd_ptr increments.
- A read while empty is ignored: no valid_o, data_o holds, no pointer change.
- Write and read in the same cycle:
  - Full: both accepted, count unchanged, no overflow.
  - Empty: write accepted, read ignored (no bypass), count goes to 1.
- Drop: sample_valid_i && full_o && !rd_acc. The sample is discarded, overflow_o sets, and pointers and count are unchanged.
- overflow_o clears when clear_ovf_i = 1. If a drop happens in the same cycle as clear_ovf_i, set wins and overflow_o stays 1.
- count update: next count = count + wr_acc - rd_acc.
- No arithmetic is applied to the data; samples pass through bit-exact.
- Reset values: data_o = 0, valid_o = 0, empty_o = 1, full_o = 0, count_o = 0, overflow_o = 0. Both pointers reset to 0; memory contents are not reset.
- Reset asserted mid-operation discards all buffered samples. The cycle after reset deasserts behaves as an empty FIFO.

## Timing

- Write to visible occupancy: count_o, empty_o and full_o reflect a write in the cycle after sample_valid_i.
- Read latency: rd_en_i in cycle N gives data_o and valid_o in cycle N+1.
- Throughput: one write and one read per cycle sustained.
- Flags (empty_o, full_o, count_o) are registered, or decoded from the registered count only; no combinational path from the inputs.
- Back-to-back reads drain one sample per cycle, with valid_o high on each of those cycles.

## Structure

- Shared package/header adc_fifo_pkg holds the ADC_DATA_W = 12 and FIFO_DEPTH_LOG2 = 4 constants, which the FIR input stage also uses.
- One sub-module, fifo_mem: simple dual-port RAM with a synchronous write port and a synchronous registered read port, suitable for distributed/LUT RAM inference.
- The top level holds the pointers, count, flags and overflow logic.

## Test plan

- Reset, then 3 writes (0x001, 0x002, 0x003), then 3 reads -> data_o sequence 0x001, 0x002, 0x003, each one cycle after its rd_en_i; count_o goes 3→0; empty_o = 1 at the end.
- Fill with 16 writes, then a 17th write (0xABC) -> full_o = 1, count_o = 16, overflow_o = 1; a full drain returns the first 16 samples only.
- While full, write and read in the same cycle -> count_o stays 16, overflow_o stays 0, the new sample is read out last.
- While empty, write and read in the same cycle -> no valid_o, count_o = 1; the next read returns the written sample.
- More than 32 mixed write/read cycles with random gaps, compared against a scoreboard queue -> order preserved across pointer wrap-around, count_o always matches.
- Assert reset_i with count_o = 5 and overflow_o = 1 -> next cycle all outputs at reset values; after reset deasserts, a read gives no valid_o.
